// File: rtl/ibex_fetch_arbiter.sv
// Two-requester instruction fetch arbiter sharing one req/gnt/rvalid memory port.
// Round-robin on ties, the selection is held until granted, and grant order is tracked to route responses.
module ibex_fetch_arbiter #(
    parameter int unsigned MaxOutstanding = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        m0_req_i,
    input  logic [31:0] m0_addr_i,
    input  logic        m1_req_i,
    input  logic [31:0] m1_addr_i,
    output logic        m0_gnt_o,
    output logic        m1_gnt_o,
    output logic        m0_rvalid_o,
    output logic        m1_rvalid_o,
    output logic        m0_err_o,
    output logic        m1_err_o,
    output logic [31:0] m_rdata_o,
    output logic        out_req_o,
    output logic [31:0] out_addr_o,
    input  logic        out_gnt_i,
    input  logic        out_rvalid_i,
    input  logic [31:0] out_rdata_i,
    input  logic        out_err_i,
    output logic        busy_o,
    output logic        protocol_err_o
);
    localparam int unsigned PW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
    localparam int unsigned CW = $clog2(MaxOutstanding + 1);
    localparam logic [CW-1:0] MaxCnt  = CW'(MaxOutstanding);
    localparam logic [PW-1:0] LastPtr = PW'(MaxOutstanding - 1);

    logic                      lock_q, lock_d, sel_q, sel_d, last_q, last_d, perr_q, perr_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [PW-1:0]             wptr_q, wptr_d, rptr_q, rptr_d;
    logic [MaxOutstanding-1:0] ids_q, ids_d;
    logic                      sel, push, pop, head;

    // A locked selection wins; otherwise the requester that did not win last time takes a tie.
    always_comb begin
        if (lock_q)                   sel = sel_q;
        else if (m0_req_i && m1_req_i) sel = ~last_q;
        else                          sel = m1_req_i;
    end

    assign out_req_o  = (sel ? m1_req_i : m0_req_i) && (cnt_q < MaxCnt);
    assign out_addr_o = sel ? m1_addr_i : m0_addr_i;
    assign push       = out_req_o & out_gnt_i & ~rst_i;
    assign m0_gnt_o   = push & ~sel;
    assign m1_gnt_o   = push & sel;

    assign pop         = out_rvalid_i & (cnt_q != '0);
    assign head        = ids_q[rptr_q];
    assign m0_rvalid_o = pop & ~head;
    assign m1_rvalid_o = pop & head;
    assign m0_err_o    = m0_rvalid_o & out_err_i;
    assign m1_err_o    = m1_rvalid_o & out_err_i;
    assign m_rdata_o   = out_rdata_i;

    assign busy_o         = out_req_o | (cnt_q != '0);
    assign protocol_err_o = perr_q;

    always_comb begin
        lock_d = lock_q;
        sel_d  = sel_q;
        last_d = last_q;
        perr_d = perr_q;
        cnt_d  = cnt_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        ids_d  = ids_q;
        if (push) begin
            ids_d[wptr_q] = sel;
            wptr_d        = (wptr_q == LastPtr) ? '0 : wptr_q + 1'b1;
            last_d        = sel;
            lock_d        = 1'b0;
        end else if (out_req_o) begin
            lock_d = 1'b1;
            sel_d  = sel;
        end
        if (pop) rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + 1'b1;
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (out_rvalid_i && (cnt_q == '0)) perr_d = 1'b1;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lock_q <= 1'b0;
            sel_q  <= 1'b0;
            last_q <= 1'b1;
            perr_q <= 1'b0;
            cnt_q  <= '0;
            wptr_q <= '0;
            rptr_q <= '0;
            ids_q  <= '0;
        end else begin
            lock_q <= lock_d;
            sel_q  <= sel_d;
            last_q <= last_d;
            perr_q <= perr_d;
            cnt_q  <= cnt_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ids_q  <= ids_d;
        end
    end
endmodule

// File: tb/tb_ibex_fetch_arbiter.sv
// Directed bench for ibex_fetch_arbiter: a queue-based arbitration model checked every cycle
// plus literal expectations at the key cycles of each scenario.
module tb_ibex_fetch_arbiter;
    localparam int MAXO = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        r0 = 1'b0, r1 = 1'b0, gnt = 1'b0, rv = 1'b0, er = 1'b0;
    logic [31:0] a0 = '0, a1 = '0, rd = '0;
    logic        m0_gnt, m1_gnt, m0_rv, m1_rv, m0_err, m1_err, oreq, busy, perr;
    logic [31:0] rdata, oaddr;

    int ncmp = 0;
    int nerr = 0;

    ibex_fetch_arbiter #(.MaxOutstanding(MAXO)) dut (
        .clk_i(clk), .rst_i(rst),
        .m0_req_i(r0), .m0_addr_i(a0), .m1_req_i(r1), .m1_addr_i(a1),
        .m0_gnt_o(m0_gnt), .m1_gnt_o(m1_gnt),
        .m0_rvalid_o(m0_rv), .m1_rvalid_o(m1_rv), .m0_err_o(m0_err), .m1_err_o(m1_err),
        .m_rdata_o(rdata),
        .out_req_o(oreq), .out_addr_o(oaddr), .out_gnt_i(gnt),
        .out_rvalid_i(rv), .out_rdata_i(rd), .out_err_i(er),
        .busy_o(busy), .protocol_err_o(perr)
    );

    always #5 clk = ~clk;

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Model: outstanding IDs as a queue in grant order, the winner of the last grant,
    // and the requester being held while the port waits for a grant (-1 = none).
    int q[$];
    int last = 1;
    int held = -1;
    bit mperr = 1'b0;

    always @(negedge clk) begin
        int  sel, head;
        bit  sreq, xreq, g, p;
        if (rst) begin
            q.delete(); last = 1; held = -1; mperr = 1'b0;
        end
        if (held >= 0)      sel = held;
        else if (r0 && r1)  sel = 1 - last;
        else if (r1)        sel = 1;
        else                sel = 0;
        sreq = (sel == 1) ? r1 : r0;
        xreq = sreq && (q.size() < MAXO);
        g    = xreq && gnt && !rst;
        p    = rv && (q.size() > 0);
        head = p ? q[0] : 0;
        cmp("m_out_req", {31'b0, oreq}, {31'b0, xreq});
        if (xreq) cmp("m_out_addr", oaddr, (sel == 1) ? a1 : a0);
        cmp("m_m0_gnt", {31'b0, m0_gnt}, {31'b0, g && sel == 0});
        cmp("m_m1_gnt", {31'b0, m1_gnt}, {31'b0, g && sel == 1});
        cmp("m_m0_rvalid", {31'b0, m0_rv}, {31'b0, p && head == 0});
        cmp("m_m1_rvalid", {31'b0, m1_rv}, {31'b0, p && head == 1});
        cmp("m_m0_err", {31'b0, m0_err}, {31'b0, p && head == 0 && er});
        cmp("m_m1_err", {31'b0, m1_err}, {31'b0, p && head == 1 && er});
        cmp("m_rdata", rdata, rd);
        cmp("m_busy", {31'b0, busy}, {31'b0, xreq || q.size() != 0});
        cmp("m_perr", {31'b0, perr}, {31'b0, mperr});
        if (!rst) begin
            if (rv && !p) mperr = 1'b1;
            if (p) void'(q.pop_front());
            if (g) begin
                q.push_back(sel); last = sel; held = -1;
            end else if (xreq) begin
                held = sel;
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic q0, input logic [31:0] d0, input logic q1, input logic [31:0] d1,
                       input logic g, input logic v, input logic [31:0] d, input logic e);
        r0 = q0; a0 = d0; r1 = q1; a1 = d1; gnt = g; rv = v; rd = d; er = e;
    endtask

    initial begin
        // Reset with both requesting: port request visible, no grants.
        drv(1, 32'h100, 1, 32'h200, 1, 0, 0, 0);
        @(negedge clk);
        cmp("rst_busy", {31'b0, busy}, 32'd1);
        cmp("rst_oreq", {31'b0, oreq}, 32'd1);
        cmp("rst_m0_gnt", {31'b0, m0_gnt}, 32'd0);
        cmp("rst_perr", {31'b0, perr}, 32'd0);
        nxt(); rst = 1'b0;

        // Alternating grants, full gating, and one-cycle-late regrant.
        @(negedge clk); cmp("rr_a_m0_gnt", {31'b0, m0_gnt}, 32'd1); cmp("rr_a_addr", oaddr, 32'h100);
        nxt();
        @(negedge clk); cmp("rr_b_m1_gnt", {31'b0, m1_gnt}, 32'd1); cmp("rr_b_addr", oaddr, 32'h200);
        nxt(); rv = 1'b1; rd = 32'h11;
        @(negedge clk); cmp("full_oreq", {31'b0, oreq}, 32'd0); cmp("full_m0_rv", {31'b0, m0_rv}, 32'd1);
        cmp("full_no_gnt", {31'b0, m0_gnt | m1_gnt}, 32'd0);
        nxt();
        @(negedge clk); cmp("rr_d_m0_gnt", {31'b0, m0_gnt}, 32'd1); cmp("rr_d_m1_rv", {31'b0, m1_rv}, 32'd1);
        nxt();
        @(negedge clk); cmp("rr_e_m1_gnt", {31'b0, m1_gnt}, 32'd1); cmp("rr_e_m0_rv", {31'b0, m0_rv}, 32'd1);
        nxt(); r0 = 1'b0; r1 = 1'b0;
        @(negedge clk); cmp("drain_m1_rv", {31'b0, m1_rv}, 32'd1);
        nxt(); rv = 1'b0;
        @(negedge clk); cmp("idle_busy", {31'b0, busy}, 32'd0);
        nxt();

        // Lock: m0 waits for grant while m1 joins; m1 follows the next cycle.
        drv(1, 32'h300, 0, 32'h400, 0, 0, 0, 0);
        @(negedge clk); cmp("lock_addr0", oaddr, 32'h300);
        nxt(); r1 = 1'b1;
        @(negedge clk); cmp("lock_addr1", oaddr, 32'h300); cmp("lock_m1_gnt", {31'b0, m1_gnt}, 32'd0);
        nxt();
        @(negedge clk); cmp("lock_addr2", oaddr, 32'h300);
        nxt(); gnt = 1'b1;
        @(negedge clk); cmp("lock_m0_gnt", {31'b0, m0_gnt}, 32'd1); cmp("lock_addr3", oaddr, 32'h300);
        nxt();
        @(negedge clk); cmp("lock_then_m1", {31'b0, m1_gnt}, 32'd1); cmp("lock_addr4", oaddr, 32'h400);
        nxt(); drv(0, 0, 0, 0, 0, 1, 32'h22, 0);
        @(negedge clk); cmp("lock_rv0", {31'b0, m0_rv}, 32'd1);
        nxt();
        @(negedge clk); cmp("lock_rv1", {31'b0, m1_rv}, 32'd1);
        nxt();

        // Response routing with an error on the second response; push+pop in one cycle.
        drv(1, 32'h500, 0, 32'h600, 1, 0, 0, 0);
        @(negedge clk); cmp("rt_m0_gnt", {31'b0, m0_gnt}, 32'd1);
        nxt(); drv(0, 32'h500, 1, 32'h600, 1, 0, 0, 0);
        @(negedge clk); cmp("rt_m1_gnt", {31'b0, m1_gnt}, 32'd1);
        nxt(); drv(0, 0, 0, 0, 0, 1, 32'hAAAA0001, 0);
        @(negedge clk); cmp("rt_rv1_m0", {31'b0, m0_rv}, 32'd1); cmp("rt_rdata1", rdata, 32'hAAAA0001);
        nxt(); drv(1, 32'h700, 0, 0, 1, 1, 32'hBBBB0002, 1);
        @(negedge clk); cmp("rt_rv2_m1", {31'b0, m1_rv}, 32'd1); cmp("rt_err2_m1", {31'b0, m1_err}, 32'd1);
        cmp("rt_err2_m0", {31'b0, m0_err}, 32'd0); cmp("rt_pushpop_gnt", {31'b0, m0_gnt}, 32'd1);
        nxt(); drv(0, 0, 0, 0, 0, 1, 32'hCCCC0003, 0);
        @(negedge clk); cmp("rt_rv3_m0", {31'b0, m0_rv}, 32'd1); cmp("rt_rdata3", rdata, 32'hCCCC0003);
        nxt(); drv(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk); cmp("rt_idle_busy", {31'b0, busy}, 32'd0);
        nxt();

        // Unexpected response: dropped, sticky error until reset.
        rv = 1'b1; rd = 32'h33;
        @(negedge clk); cmp("pe_no_rv", {30'b0, m1_rv, m0_rv}, 32'd0); cmp("pe_not_yet", {31'b0, perr}, 32'd0);
        nxt(); rv = 1'b0;
        @(negedge clk); cmp("pe_set", {31'b0, perr}, 32'd1);
        nxt(); nxt();
        @(negedge clk); cmp("pe_held", {31'b0, perr}, 32'd1);
        nxt(); rst = 1'b1;
        @(negedge clk); cmp("pe_cleared", {31'b0, perr}, 32'd0);
        nxt(); rst = 1'b0;

        // Reset with two outstanding after m0 won last: tie goes to m0 again, old IDs discarded.
        drv(1, 32'h800, 0, 32'h900, 1, 0, 0, 0);
        nxt(); nxt();
        @(negedge clk); cmp("r33_full", {31'b0, oreq}, 32'd0);
        nxt(); r0 = 1'b0; rst = 1'b1;
        @(negedge clk); cmp("r33_busy_rst", {31'b0, busy}, 32'd0);
        nxt(); rst = 1'b0;
        @(negedge clk); cmp("r33_busy", {31'b0, busy}, 32'd0);
        nxt(); r0 = 1'b1; r1 = 1'b1;
        @(negedge clk); cmp("r33_tie_m0", {31'b0, m0_gnt}, 32'd1); cmp("r33_addr", oaddr, 32'h800);
        nxt(); drv(0, 0, 0, 0, 0, 1, 32'h44, 0);
        @(negedge clk); cmp("r33_rv_m0", {31'b0, m0_rv}, 32'd1);
        nxt();
        @(negedge clk); cmp("r33_stale_drop", {30'b0, m1_rv, m0_rv}, 32'd0);
        nxt(); rv = 1'b0;
        @(negedge clk); cmp("r33_perr", {31'b0, perr}, 32'd1);
        nxt();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
